// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core: latches decode state into E,
// applies RAW forwarding to the ALU operands, detects load-use hazards and counts bubbles.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic [4:0]       rd_D,
    input  logic [XLEN-1:0]  rd1_D,
    input  logic [XLEN-1:0]  rd2_D,
    input  logic [XLEN-1:0]  imm_D,
    input  logic [XLEN-1:0]  pc_D,
    input  logic             reg_wr_D,
    input  logic             mem_wr_D,
    input  logic             alu_src_D,
    input  logic             branch_D,
    input  logic             jump_D,
    input  logic [1:0]       result_src_D,
    input  logic [3:0]       alu_ctrl_D,
    input  logic             flush_E,
    input  logic             stall_E,
    input  logic [1:0]       forwardAE,
    input  logic [1:0]       forwardBE,
    input  logic [XLEN-1:0]  alu_result_M,
    input  logic [XLEN-1:0]  result_W,
    output logic [4:0]       rs1_E,
    output logic [4:0]       rs2_E,
    output logic [4:0]       rd_E,
    output logic [XLEN-1:0]  pc_E,
    output logic [XLEN-1:0]  imm_E,
    output logic             reg_wr_E,
    output logic             mem_wr_E,
    output logic             branch_E,
    output logic             jump_E,
    output logic [1:0]       result_src_E,
    output logic [3:0]       alu_ctrl_E,
    output logic [XLEN-1:0]  src_a_E,
    output logic [XLEN-1:0]  src_b_E,
    output logic [XLEN-1:0]  write_data_E,
    output logic             lw_stall,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef struct packed {
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            reg_wr;
        logic            mem_wr;
        logic            alu_src;
        logic            branch;
        logic            jump;
        logic [1:0]      result_src;
        logic [3:0]      alu_ctrl;
    } ex_regs_t;

    ex_regs_t d_regs, e_regs;
    logic     bubble;

    assign d_regs = '{rs1: rs1_D, rs2: rs2_D, rd: rd_D, rd1: rd1_D, rd2: rd2_D,
                      imm: imm_D, pc: pc_D, reg_wr: reg_wr_D, mem_wr: mem_wr_D,
                      alu_src: alu_src_D, branch: branch_D, jump: jump_D,
                      result_src: result_src_D, alu_ctrl: alu_ctrl_D};

    // A held E stage cannot take a bubble, so the hazard is masked while stalled.
    assign lw_stall = !stall_E && (e_regs.result_src == 2'b01) && (e_regs.rd != 5'd0) &&
                      ((rs1_D == e_regs.rd) || (rs2_D == e_regs.rd));
    assign bubble   = flush_E || lw_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            e_regs <= '0;
        else if (!stall_E) begin
            if (bubble)
                e_regs <= '0;
            else
                e_regs <= d_regs;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bubble_cnt <= '0;
        else if (!stall_E && bubble && (bubble_cnt != {CNT_W{1'b1}}))
            bubble_cnt <= bubble_cnt + 1'b1;
    end

    function automatic logic [XLEN-1:0] fwd_sel(input logic [1:0] sel,
                                                input logic [XLEN-1:0] rf,
                                                input logic [XLEN-1:0] m_val,
                                                input logic [XLEN-1:0] w_val);
        case (sel)
            2'b01:   fwd_sel = w_val;
            2'b11:   fwd_sel = m_val;
            default: fwd_sel = rf;
        endcase
    endfunction

    assign src_a_E      = fwd_sel(forwardAE, e_regs.rd1, alu_result_M, result_W);
    assign write_data_E = fwd_sel(forwardBE, e_regs.rd2, alu_result_M, result_W);
    assign src_b_E      = e_regs.alu_src ? e_regs.imm : write_data_E;

    assign rs1_E        = e_regs.rs1;
    assign rs2_E        = e_regs.rs2;
    assign rd_E         = e_regs.rd;
    assign pc_E         = e_regs.pc;
    assign imm_E        = e_regs.imm;
    assign reg_wr_E     = e_regs.reg_wr;
    assign mem_wr_E     = e_regs.mem_wr;
    assign branch_E     = e_regs.branch;
    assign jump_E       = e_regs.jump;
    assign result_src_E = e_regs.result_src;
    assign alu_ctrl_E   = e_regs.alu_ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic checked against
// a cycle-level behavioural model of the E stage and its bubble counter.
module tb_id_ex_stage;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic clk = 1'b1;
    logic rst;
    logic [4:0] rs1_D, rs2_D, rd_D;
    logic [XLEN-1:0] rd1_D, rd2_D, imm_D, pc_D;
    logic reg_wr_D, mem_wr_D, alu_src_D, branch_D, jump_D;
    logic [1:0] result_src_D;
    logic [3:0] alu_ctrl_D;
    logic flush_E, stall_E;
    logic [1:0] forwardAE, forwardBE;
    logic [XLEN-1:0] alu_result_M, result_W;
    logic [4:0] rs1_E, rs2_E, rd_E;
    logic [XLEN-1:0] pc_E, imm_E, src_a_E, src_b_E, write_data_E;
    logic reg_wr_E, mem_wr_E, branch_E, jump_E, lw_stall;
    logic [1:0] result_src_E;
    logic [3:0] alu_ctrl_E;
    logic [CNT_W-1:0] bubble_cnt;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D),
        .rd1_D(rd1_D), .rd2_D(rd2_D), .imm_D(imm_D), .pc_D(pc_D),
        .reg_wr_D(reg_wr_D), .mem_wr_D(mem_wr_D), .alu_src_D(alu_src_D),
        .branch_D(branch_D), .jump_D(jump_D),
        .result_src_D(result_src_D), .alu_ctrl_D(alu_ctrl_D),
        .flush_E(flush_E), .stall_E(stall_E),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .alu_result_M(alu_result_M), .result_W(result_W),
        .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
        .pc_E(pc_E), .imm_E(imm_E),
        .reg_wr_E(reg_wr_E), .mem_wr_E(mem_wr_E), .branch_E(branch_E), .jump_E(jump_E),
        .result_src_E(result_src_E), .alu_ctrl_E(alu_ctrl_E),
        .src_a_E(src_a_E), .src_b_E(src_b_E), .write_data_E(write_data_E),
        .lw_stall(lw_stall), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // Model of the instruction sitting in E, as one record per field.
    logic [4:0]      m_rs1, m_rs2, m_rd;
    logic [XLEN-1:0] m_rd1, m_rd2, m_imm, m_pc;
    logic [9:0]      m_ctrl;    // {reg_wr, mem_wr, branch, jump, result_src, alu_ctrl}
    logic            m_alu_src;
    int              m_bubbles;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_clear();
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_pc = 0;
        m_ctrl = 0; m_alu_src = 0;
    endtask

    function automatic logic model_hazard();
        // E holds a load with a real destination that the D instruction reads
        return !stall_E && m_ctrl[5:4] == 2'b01 && m_rd != 0 && (rs1_D == m_rd || rs2_D == m_rd);
    endfunction

    function automatic logic [XLEN-1:0] model_fwd(input logic [1:0] sel, input logic [XLEN-1:0] rf);
        logic [XLEN-1:0] srcs [4];
        srcs[0] = rf; srcs[1] = result_W; srcs[2] = rf; srcs[3] = alu_result_M;
        return srcs[sel];
    endfunction

    function automatic logic [CNT_W-1:0] model_cnt();
        int sat = (1 << CNT_W) - 1;
        return CNT_W'(m_bubbles > sat ? sat : m_bubbles);
    endfunction

    task automatic check_comb(input string ph);
        logic [XLEN-1:0] fb;
        fb = model_fwd(forwardBE, m_rd2);
        chk({ph, ".lw_stall"}, XLEN'(lw_stall), XLEN'(model_hazard()));
        chk({ph, ".src_a"}, src_a_E, model_fwd(forwardAE, m_rd1));
        chk({ph, ".write_data"}, write_data_E, fb);
        chk({ph, ".src_b"}, src_b_E, m_alu_src ? m_imm : fb);
    endtask

    task automatic check_regs(input string ph);
        chk({ph, ".idx"}, XLEN'({rs1_E, rs2_E, rd_E}), XLEN'({m_rs1, m_rs2, m_rd}));
        chk({ph, ".pc"}, pc_E, m_pc);
        chk({ph, ".imm"}, imm_E, m_imm);
        chk({ph, ".ctrl"}, XLEN'({reg_wr_E, mem_wr_E, branch_E, jump_E, result_src_E, alu_ctrl_E}),
            XLEN'(m_ctrl));
        chk({ph, ".cnt"}, XLEN'(bubble_cnt), XLEN'(model_cnt()));
    endtask

    // Entered just after a rising edge with the new D inputs already driven.
    task automatic cycle(input string ph);
        logic haz;
        #2 check_comb(ph);
        @(posedge clk);
        haz = model_hazard();
        if (!stall_E) begin
            if (flush_E || haz) begin
                model_clear();
                m_bubbles++;
            end else begin
                m_rs1 = rs1_D; m_rs2 = rs2_D; m_rd = rd_D;
                m_rd1 = rd1_D; m_rd2 = rd2_D; m_imm = imm_D; m_pc = pc_D;
                m_ctrl = {reg_wr_D, mem_wr_D, branch_D, jump_D, result_src_D, alu_ctrl_D};
                m_alu_src = alu_src_D;
            end
        end
        #1 check_regs(ph);
    endtask

    task automatic set_instr(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                             input logic [1:0] rsrc, input logic wr);
        rs1_D = s1; rs2_D = s2; rd_D = d; result_src_D = rsrc; reg_wr_D = wr;
        rd1_D = $urandom; rd2_D = $urandom; imm_D = $urandom; pc_D = $urandom;
        mem_wr_D = 0; alu_src_D = 0; branch_D = 0; jump_D = 0; alu_ctrl_D = 4'($urandom);
    endtask

    task automatic rand_inputs();
        set_instr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  2'($urandom), 1'($urandom));
        mem_wr_D = 1'($urandom); alu_src_D = 1'($urandom);
        branch_D = 1'($urandom); jump_D = 1'($urandom);
        flush_E = ($urandom_range(0, 7) == 0);
        stall_E = ($urandom_range(0, 5) == 0);
        forwardAE = 2'($urandom); forwardBE = 2'($urandom);
        alu_result_M = $urandom; result_W = $urandom;
    endtask

    task automatic async_reset(input string ph);
        #2 rst = 1'b1;
        #1;
        model_clear();
        m_bubbles = 0;
        check_regs(ph);
        chk({ph, ".lw_stall"}, XLEN'(lw_stall), '0);
        chk({ph, ".src_a"}, src_a_E, model_fwd(forwardAE, '0));
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [XLEN-1:0] fwd_exp [4];
        logic [CNT_W-1:0] c0;
        rst = 1'b1;
        set_instr(0, 0, 0, 0, 0);
        flush_E = 0; stall_E = 0; forwardAE = 0; forwardBE = 0;
        alu_result_M = 0; result_W = 0;
        model_clear();
        m_bubbles = 0;
        #1 check_regs("reset");
        rst = 1'b0;

        // Forwarding: rd1_E=0x11, M=0x22, W=0x33, E held while sweeping the selects
        set_instr(1, 2, 3, 2'b00, 1);
        rd1_D = 32'h11; rd2_D = 32'h55; imm_D = 32'h4;
        cycle("fwd_load");
        stall_E = 1; alu_result_M = 32'h22; result_W = 32'h33;
        fwd_exp[0] = 32'h11; fwd_exp[1] = 32'h33; fwd_exp[2] = 32'h11; fwd_exp[3] = 32'h22;
        for (int i = 0; i < 4; i++) begin
            forwardAE = 2'(i); forwardBE = 2'(i);
            #2 chk("fwd_a_const", src_a_E, fwd_exp[i]);
            cycle("fwd_sweep");
        end
        stall_E = 0;
        set_instr(1, 2, 3, 2'b00, 1);
        rd1_D = 32'h11; rd2_D = 32'h55; imm_D = 32'h4; alu_src_D = 1;
        forwardBE = 2'b11;
        cycle("imm_load");
        #2 chk("src_b_imm", src_b_E, 32'h4);
        chk("wdata_fwd", write_data_E, 32'h22);
        cycle("imm_hold");

        // Load-use: lw x5 in E, add x6,x5,x1 in D
        set_instr(2, 0, 5, 2'b01, 1);
        cycle("lw_enter");
        set_instr(5, 1, 6, 2'b00, 1);
        #2 chk("lw_stall_hit", XLEN'(lw_stall), 1);
        cycle("lw_bubble");
        chk("lw_bubble_regwr", XLEN'(reg_wr_E), 0);
        chk("lw_bubble_cnt", XLEN'(bubble_cnt), 1);
        cycle("lw_dep_enter");
        // lw to x0 never creates a hazard
        set_instr(2, 0, 0, 2'b01, 1);
        cycle("lw_x0_enter");
        set_instr(0, 0, 6, 2'b00, 1);
        #2 chk("lw_x0_stall", XLEN'(lw_stall), 0);
        cycle("lw_x0_dep");

        // Flush, then flush coincident with load-use
        c0 = bubble_cnt;
        set_instr(3, 4, 7, 2'b10, 1); jump_D = 1; flush_E = 1;
        cycle("flush");
        chk("flush_cnt", XLEN'(bubble_cnt), XLEN'(c0 + 1'b1));
        flush_E = 0;
        set_instr(1, 2, 9, 2'b01, 1);
        cycle("lw2_enter");
        set_instr(9, 9, 10, 2'b00, 1); flush_E = 1;
        #2 chk("flush_lw_stall", XLEN'(lw_stall), 1);
        cycle("flush_and_lw");
        chk("flush_lw_cnt", XLEN'(bubble_cnt), XLEN'(c0 + 2'd2));
        flush_E = 0;

        // Stall dominates flush and hides the hazard
        set_instr(1, 2, 11, 2'b01, 1);
        cycle("lw3_enter");
        stall_E = 1; flush_E = 1;
        for (int i = 0; i < 3; i++) begin
            set_instr(11, 11, 5'(12 + i), 2'($urandom), 1);
            cycle("stall_hold");
            chk("stall_rd", XLEN'(rd_E), 11);
        end
        stall_E = 0; flush_E = 0;

        // Randomized traffic with a reset in the middle
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            cycle("rand");
            if (i == 150) async_reset("mid_reset");
        end

        // Saturation: 20 forced bubbles
        stall_E = 0; flush_E = 1;
        for (int i = 0; i < 20; i++) begin
            set_instr(1, 2, 3, 0, 1);
            cycle("sat");
        end
        chk("sat_cnt", XLEN'(bubble_cnt), 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage RV32I core. Registers decode-stage operands and control into the execute stage and applies the forwarding selects from the RAW forwarding unit to produce the ALU sources and store data. It detects load-use hazards against the instruction currently in E, inserts bubbles on flush or load-use, and counts inserted bubbles for performance monitoring.

## Interface
Parameters:
- XLEN, 32, datapath width
- CNT_W, 16, width of bubble counter

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rs1_D, rs2_D, rd_D  in  5 each  decode register indices
- rd1_D, rd2_D  in  XLEN  register-file read data
- imm_D, pc_D  in  XLEN  extended immediate, PC
- reg_wr_D, mem_wr_D, alu_src_D, branch_D, jump_D  in  1 each  decode control
- result_src_D  in  2  00 ALU, 01 load, 10 PC+4
- alu_ctrl_D  in  4  ALU operation
- flush_E  in  1  branch/jump redirect; bubble E
- stall_E  in  1  downstream stall; hold E
- forwardAE, forwardBE  in  2 each  00 regfile, 01 W result, 11 M ALU result, 10 treated as 00
- alu_result_M, result_W  in  XLEN  forwarding sources
- rs1_E, rs2_E, rd_E  out  5 each  registered indices (to forwarding unit)
- pc_E, imm_E  out  XLEN  registered
- reg_wr_E, mem_wr_E, branch_E, jump_E  out  1 each  registered control
- result_src_E  out  2; alu_ctrl_E  out  4
- src_a_E, src_b_E, write_data_E  out  XLEN  forwarded operands
- lw_stall  out  1  load-use hazard; stalls F and D
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles

## Operation
- Register update priority per edge: rst > stall_E (hold all) > bubble (flush_E or lw_stall) > load from D.
- Bubble: all E registers cleared to 0 (indices, data, control), i.e. a NOP with reg_wr_E=0, mem_wr_E=0, branch_E=0, jump_E=0.
- lw_stall = (result_src_E==2'b01) & (rd_E!=0) & ((rs1_D==rd_E) | (rs2_D==rd_E)); combinational from E registers and D inputs; forced 0 while stall_E=1.
- Forward mux A: 00/10 -> rd1_E, 01 -> result_W, 11 -> alu_result_M. Mux B identical on rd2_E.
- src_a_E = fwd A; write_data_E = fwd B; src_b_E = alu_src_E ? imm_E : fwd B.
- bubble_cnt increments by 1 on each edge where a bubble is written and stall_E=0; saturates at all-ones; no wrap.
- flush_E and lw_stall together: single bubble, counter +1.

## Timing
- Reset (async, immediate): all registered outputs 0, bubble_cnt 0; lw_stall therefore 0 and forwarded outputs reflect zero registers.
- D-to-E latency: 1 cycle. Forward muxes and lw_stall: 0-cycle combinational.
- Load-use: cycle N load in E, dependent in D -> lw_stall=1 in N; edge N+1 loads bubble into E, D held upstream; in N+1 lw_stall=0, load in M; dependent enters E at N+2 and receives forwardAE/BE=01 from W.
- stall_E=1 holds every E register and the counter, regardless of flush_E.
- Reset deasserted mid-stream: first edge after release loads D normally.

## Test plan
- Reset: assert rst mid-cycle with nonzero E contents -> all E outputs and bubble_cnt read 0 before next edge.
- Forwarding: rd1_E=0x11, alu_result_M=0x22, result_W=0x33; forwardAE=00/01/11/10 -> src_a_E=0x11/0x33/0x22/0x11; alu_src_E=1, imm_E=0x4 -> src_b_E=0x4, write_data_E=fwd B.
- Load-use: lw x5 in E, add x6,x5,x1 in D -> lw_stall=1, next cycle E is bubble (reg_wr_E=0), bubble_cnt=1; lw with rd=x0 -> lw_stall=0.
- Flush: flush_E=1 with valid D -> E all zero, count +1; flush_E and lw_stall together -> count +1 only.
- Stall: stall_E=1 with flush_E=1 and changing D -> E outputs unchanged, lw_stall=0, count unchanged.
- Saturation: CNT_W=4, force 20 bubbles -> bubble_cnt stops at 0xF.
